// File: rtl/ctrl_store_loader.sv
// Framed byte-stream loader that assembles little-endian control words and writes them into the control store.
// Optional checksum trailer enabled by defining CTRL_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps

module ctrl_store_loader #(
    parameter int          WORD_W    = 26,
    parameter int          ADDR_W    = 7,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;
    // Word counter must hold DEPTH itself, and COUNT values up to 255 for the range check.
    localparam int CNT_W = (ADDR_W >= 8) ? ADDR_W + 1 : 9;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_ptr;
    logic [CNT_W-1:0]  words_left;
    logic [1:0]        byte_idx;
    logic [23:0]       shift_q;
    logic              hs;
    logic [31:0]       word;
    logic [CNT_W-1:0]  count_val;
    logic              excess;
    logic              last_word;
`ifdef CTRL_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign in_ready  = ~rst;
    assign hs        = in_valid & in_ready;
    // The incoming byte is the most significant one of the word being completed.
    assign word      = {in_data, shift_q};
    assign excess    = (word >> WORD_W) != 32'd0;
    assign count_val = (in_data == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(in_data);
    assign last_word = (words_left == CNT_W'(1));
    assign busy      = (state == S_ADDR) || (state == S_COUNT) ||
                       (state == S_DATA) || (state == S_CSUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_ptr   <= '0;
            words_left <= '0;
            byte_idx   <= '0;
            shift_q    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef CTRL_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            // NOTE: strobes default low every cycle so a single assignment below yields a one-cycle pulse.
            wr_en <= 1'b0;
            done  <= 1'b0;
            if (hs) begin
                case (state)
                    IDLE: begin
                        if (in_data == SYNC_BYTE) begin
                            state <= S_ADDR;
`ifdef CTRL_LOADER_CHECKSUM_EN
                            csum  <= '0;
`endif
                        end
                    end
                    S_ADDR: begin
                        addr_ptr <= in_data[ADDR_W-1:0];
                        state    <= S_COUNT;
`ifdef CTRL_LOADER_CHECKSUM_EN
                        csum     <= csum ^ in_data;
`endif
                    end
                    S_COUNT: begin
`ifdef CTRL_LOADER_CHECKSUM_EN
                        csum <= csum ^ in_data;
`endif
                        if (count_val > CNT_W'(DEPTH)) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end else begin
                            words_left <= count_val;
                            byte_idx   <= 2'd0;
                            state      <= S_DATA;
                        end
                    end
                    S_DATA: begin
`ifdef CTRL_LOADER_CHECKSUM_EN
                        csum     <= csum ^ in_data;
`endif
                        shift_q  <= word[31:8];
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            if (excess) begin
                                state <= S_ERR;
                                err   <= 1'b1;
                            end else begin
                                wr_en      <= 1'b1;
                                wr_addr    <= addr_ptr;
                                wr_data    <= word[WORD_W-1:0];
                                addr_ptr   <= addr_ptr + 1'b1;
                                words_left <= words_left - 1'b1;
                                if (last_word) begin
`ifdef CTRL_LOADER_CHECKSUM_EN
                                    state <= S_CSUM;
`else
                                    state <= IDLE;
                                    done  <= 1'b1;
`endif
                                end
                            end
                        end
                    end
`ifdef CTRL_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (in_data == csum) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
`endif
                    S_ERR: begin
                        if (in_data == SYNC_BYTE) begin
                            err   <= 1'b0;
                            state <= S_ADDR;
`ifdef CTRL_LOADER_CHECKSUM_EN
                            csum  <= '0;
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ctrl_store_loader.sv
// Scoreboard bench for ctrl_store_loader: directed frames push expected write/done events, a monitor compares.
// Adapts frame endings to CTRL_LOADER_CHECKSUM_EN when that macro is defined.
`timescale 1ns/1ps

module tb_ctrl_store_loader;

    localparam int WORD_W = 26;
    localparam int ADDR_W = 7;
`ifdef CTRL_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] data;
        logic              done;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    ctrl_store_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue the expected write, then stream the word LSB first.
    task automatic expect_word(input logic [ADDR_W-1:0] a, input logic [31:0] w, input bit last);
        ev_t e;
        e.wr   = 1'b1;
        e.addr = a;
        e.data = w[WORD_W-1:0];
        e.done = last && !CSUM_ON;
        exp_q.push_back(e);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic frame_end(input logic [7:0] cs);
        ev_t e;
        if (CSUM_ON) begin
            e = '0;
            e.done = 1'b1;
            exp_q.push_back(e);
            send_byte(cs);
        end
    endtask

    // Monitor: any write strobe or done pulse must match the oldest expectation.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (wr_en || done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {30'd0, wr_en, done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_en", 32'(wr_en), 32'(e.wr));
                    if (e.wr) begin
                        check("wr_addr", 32'(wr_addr), 32'(e.addr));
                        check("wr_data", 32'(wr_data), 32'(e.data));
                    end
                    check("done", 32'(done), 32'(e.done));
                end
            end
        end
    end

    initial begin
        logic [7:0]  x;
        logic [31:0] w;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(posedge clk);
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        idle(1);

        // Garbage before SYNC, then a single-word frame.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("garbage_busy", 32'(busy), 32'd0);
        send_byte(8'hA5);
        check("sync_busy", 32'(busy), 32'd1);
        send_byte(8'h10);
        send_byte(8'h01);
        expect_word(7'h10, 32'h0200_0123, 1'b1);
        frame_end(8'h31);
        idle(1);
        check("frame1_err", 32'(err), 32'd0);
        check("frame1_busy", 32'(busy), 32'd0);

        // Valid gaps mid-word.
        send_byte(8'hA5);
        send_byte(8'h20);
        send_byte(8'h01);
        exp_q.push_back('{wr: 1'b1, addr: 7'h20, data: 26'h322_3344, done: !CSUM_ON});
        send_byte(8'h44);
        idle(2);
        check("gap_busy", 32'(busy), 32'd1);
        send_byte(8'h33);
        idle(3);
        send_byte(8'h22);
        send_byte(8'h03);
        frame_end(8'h77);
        idle(1);

        // Address wrap 0x7F -> 0x00.
        send_byte(8'hA5);
        send_byte(8'h7F);
        send_byte(8'h02);
        expect_word(7'h7F, 32'h0000_0001, 1'b0);
        expect_word(7'h00, 32'h0000_0002, 1'b1);
        frame_end(8'h7E);
        idle(1);

        // Excess word bits: no write, sticky error until SYNC.
        send_byte(8'hA5);
        send_byte(8'h30);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h04);
        check("excess_err", 32'(err), 32'd1);
        check("excess_busy", 32'(busy), 32'd0);
        send_byte(8'h10);
        check("err_sticky", 32'(err), 32'd1);
        send_byte(8'hA5);
        check("err_cleared", 32'(err), 32'd0);
        send_byte(8'h40);
        send_byte(8'h01);
        expect_word(7'h40, 32'h0000_0005, 1'b1);
        frame_end(8'h44);
        idle(1);
        check("recover_err", 32'(err), 32'd0);

        // COUNT out of range errors before any data byte.
        send_byte(8'hA5);
        send_byte(8'h50);
        send_byte(8'h81);
        check("count_err", 32'(err), 32'd1);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        check("count_err_hold", 32'(err), 32'd1);

`ifdef CTRL_LOADER_CHECKSUM_EN
        // Bad checksum: write lands, no done, error flagged.
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h01);
        expect_word(7'h10, 32'h0200_0123, 1'b0);
        send_byte(8'h30);
        check("csum_err", 32'(err), 32'd1);
        send_byte(8'hA5);
        check("csum_err_clear", 32'(err), 32'd0);
        send_byte(8'h10);
        send_byte(8'h01);
        expect_word(7'h10, 32'h0200_0123, 1'b1);
        frame_end(8'h31);
        idle(1);
        check("csum_recover_err", 32'(err), 32'd0);
`endif

        // Reset after two data bytes: frame aborted, outputs cleared.
        send_byte(8'hA5);
        send_byte(8'h60);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_wr_addr", 32'(wr_addr), 32'd0);
        check("midrst_wr_data", 32'(wr_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        rst = 1'b0;
        send_byte(8'h33);
        send_byte(8'h44);
        idle(1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Full-depth frame (COUNT=0), bytes back-to-back.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        x = 8'h00;
        for (int i = 0; i < 128; i++) begin
            w = {6'd0, 2'(i), 8'h00, 8'(i) ^ 8'h5A, 8'(i)};
            x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            expect_word(7'(i), w, i == 127);
        end
        frame_end(x);
        idle(2);
        check("full_err", 32'(err), 32'd0);
        check("full_busy", 32'(busy), 32'd0);

        idle(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_store_loader.md
# ctrl_store_loader

Byte-stream loader that writes microcode words into the writable control store read by the instruction decoder. It accepts framed bytes over a ready/valid link and assembles little-endian 26-bit control words. It issues one write per word at auto-incrementing addresses and reports frame completion or error. It replaces the power-up file load when the control store is built as RAM.

## Interface
Parameters:
- `WORD_W`, 26, control word width; must be ≤ 32.
- `ADDR_W`, 7, control store address width; depth is 2**ADDR_W.
- `SYNC_BYTE`, 8'hA5, frame start marker.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  byte available.
- `in_data`  in  8  byte value.
- `in_ready`  out  1  loader accepts byte. A byte transfers when `in_valid && in_ready`.
- `wr_en`  out  1  control store write strobe, one cycle per word.
- `wr_addr`  out  ADDR_W  write address.
- `wr_data`  out  WORD_W  write data.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse when a frame completes cleanly.
- `err`  out  1  sticky frame error.

## Operation
- Frame layout: SYNC, ADDR, COUNT, then COUNT×4 data bytes (LSB first per word), then CSUM (only with the checksum macro; see Configuration).
- States:
  - IDLE: non-SYNC bytes are discarded. SYNC → S_ADDR.
  - S_ADDR: latches `addr_ptr = in_data[ADDR_W-1:0]`, then → S_COUNT.
  - S_COUNT: COUNT 0 means 2**ADDR_W. COUNT > 2**ADDR_W → ERR; otherwise latch `words_left`, → S_DATA.
  - S_DATA: a 2-bit byte index shifts bytes into a 32-bit assembly register.
  - On the 4th byte:
    - If assembled bits [31:WORD_W] are nonzero → ERR, and no write.
    - Otherwise write `wr_data = asm[WORD_W-1:0]` at `addr_ptr`, increment `addr_ptr` modulo 2**ADDR_W (127 wraps to 0), and decrement `words_left`.
    - Last word → S_CSUM, or → IDLE with `done` when the macro is off.
  - S_CSUM: checks the byte against the running XOR. Match → IDLE with `done`; mismatch → ERR.
  - ERR: `err`=1. Bytes are ignored except SYNC, which clears `err` and → S_ADDR.
- Running XOR covers ADDR, COUNT and every data byte, but not SYNC. It is cleared on SYNC.
- Words already written before an error stay written. `err` marks the store content as untrusted.
- `in_ready` is 1 in every state after reset; the loader never back-pressures.
- `busy` = 1 in S_ADDR, S_COUNT, S_DATA and S_CSUM.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `err`=0, `in_ready`=0 during the reset cycle. State → IDLE.
- `wr_en`/`wr_addr`/`wr_data` are registered. They are valid in the cycle after the 4th-byte handshake, and `wr_en` is high for exactly one cycle.
- `done` pulses in the cycle after the final handshake (CSUM byte, or last data byte without the macro). It coincides with the last `wr_en` when the macro is off.
- `err` rises in the cycle after the offending handshake.
- Back-to-back bytes every cycle are supported. Minimum frame without the macro is 3+4N cycles.
- `rst` mid-frame aborts immediately. No further writes occur; any write already registered is dropped in the reset cycle.
- `in_valid` low stalls the state machine; no timeout.

## Configuration
- `CTRL_LOADER_CHECKSUM_EN` defined:
  - S_CSUM is present and the XOR byte is required after the data.
  - `done` only follows a matching checksum.
- Undefined:
  - No checksum byte and no XOR logic.
  - The frame ends after the last data byte.
  - Errors come only from COUNT range or excess word bits.

## Test plan
- Macro on: A5, 10, 01, 23 01 00 02, CSUM=10^01^23^01^00^02=0x31 → one write addr 0x10, data 26'h2000123; `done` pulse; `err`=0.
- Wrap: A5, 7F, 02, two words 0x1 and 0x2, correct CSUM → writes addr 0x7F=0x1 then addr 0x00=0x2.
- Bad checksum: frame as in the first scenario with CSUM=0x30 → write still occurs, `err`=1, no `done`. A following valid frame clears `err` and completes.
- Excess bits: 4th data byte 0x04 (bit 26 set) → no `wr_en`, `err`=1. COUNT=0x81 → `err`=1 with no data bytes consumed.
- Garbage/idle and reset: bytes 00 FF 5A before SYNC are ignored. `in_valid` gaps mid-word leave data unchanged. `rst` after 2 data bytes → no write; outputs return to 0.
- Macro off: A5, 00, 00 (128 words) streamed back-to-back → 128 writes at addr 0..127, `done` with the last `wr_en`.
